// File: rtl/notch_seq_pkg.sv
// Shared state encoding and sizing helpers for the notch filter sample-rate controller.
package notch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        WAIT = 2'd2
    } state_t;

    // WAIT timer must be able to count up to TIMEOUT inclusive.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/notch_rate_div.sv
// Programmable sample-rate divider: one tick every div_val+1 cycles while enabled.
module notch_rate_div
    import notch_seq_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_val,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // >= lets a live decrease of div_val fire at once instead of wrapping the counter.
    assign tick = enable && (cnt >= div_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/notch_sequencer.sv
// Sample-rate controller for one notch filter: triggers the filter, collects its
// result, and supervises timing with a sticky timeout flag and an overrun counter.
module notch_sequencer
    import notch_seq_pkg::*;
#(
    parameter int DATA_SIZE = 24,
    parameter int DIV_WIDTH = 16,
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 clr_status,
    input  logic [DATA_SIZE-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [DATA_SIZE-1:0] filt_data_in,
    output logic                 filt_sample_trig,
    input  logic [DATA_SIZE-1:0] filt_data_out,
    input  logic                 filt_done,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 timeout_flag,
    output logic [CNT_WIDTH-1:0] overrun_cnt
);

    localparam int TMR_W = timer_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic                 tick;
    logic [DATA_SIZE-1:0] adc_hold;
    logic [DATA_SIZE-1:0] sample;
    logic [TMR_W-1:0]     timer;
    logic                 done_hit;
    logic                 time_out;
    logic                 drop;
    logic [CNT_WIDTH-1:0] ovr_base;
    logic [CNT_WIDTH-1:0] ovr_nxt;

    notch_rate_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_rate_div (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .div_val (div_val),
        .tick    (tick)
    );

    // A sample arriving in the tick cycle bypasses the hold register.
    assign sample           = adc_valid ? adc_data : adc_hold;
    assign filt_sample_trig = (state == TRIG);
    assign busy             = (state != IDLE);
    assign drop             = tick && (state != IDLE);

    always_comb begin
        state_nxt = state;
        done_hit  = 1'b0;
        time_out  = 1'b0;
        case (state)
            IDLE: if (tick) state_nxt = TRIG;
            TRIG: state_nxt = WAIT;
            WAIT: begin
                if (filt_done) begin
                    done_hit  = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TMO_LAST) begin
                    time_out  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear is applied before a same-cycle overrun increment.
    always_comb begin
        ovr_base = clr_status ? '0 : overrun_cnt;
        ovr_nxt  = drop ? sat_inc(ovr_base) : ovr_base;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            adc_hold     <= '0;
            filt_data_in <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            timeout_flag <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= (state == WAIT) ? timer + 1'b1 : '0;
            out_valid    <= done_hit;
            timeout_flag <= time_out | (timeout_flag & ~clr_status);
            overrun_cnt  <= ovr_nxt;
            if (adc_valid) adc_hold <= adc_data;
            if (state == IDLE && tick) filt_data_in <= sample;
            if (done_hit) out_data <= filt_data_out;
        end
    end

endmodule

// File: doc/notch_sequencer.md
Name: notch_sequencer

Overview:
Sample-rate controller for one notch filter instance (filtr_a-style datapath: data_in / sample_trig / data_out / filter_done).
- Generates the filter sample strobe from a programmable clock divider and presents the latest ADC sample to the filter.
- Waits for filter completion, then registers the result with a one-cycle valid pulse.
- Supervises timing: sticky timeout flag, saturating overrun counter.
- Sits between the ADC front-end and the notch filter in the FPGA top level.

Parameters:
DATA_SIZE, 24, sample width (matches filter DATA_SIZE)
DIV_WIDTH, 16, width of the rate divider value
TIMEOUT, 64, max cycles in WAIT for filter done before abort
CNT_WIDTH, 8, width of the saturating overrun counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = generate samples; 0 = divider held at 0, no new triggers
div_val  in  DIV_WIDTH  sample period minus 1, in clk cycles
clr_status  in  1  one-cycle pulse: clears timeout_flag and overrun_cnt
adc_data  in  DATA_SIZE  ADC sample
adc_valid  in  1  adc_data valid this cycle
filt_data_in  out  DATA_SIZE  sample driven to filter data_in
filt_sample_trig  out  1  one-cycle pulse to filter sample_trig
filt_data_out  in  DATA_SIZE  filter data_out
filt_done  in  1  filter filter_done
out_data  out  DATA_SIZE  registered filter result
out_valid  out  1  one-cycle pulse, out_data new
busy  out  1  state != IDLE
timeout_flag  out  1  sticky: filter failed to finish within TIMEOUT
overrun_cnt  out  CNT_WIDTH  saturating count of dropped ticks

Behaviour:
- Reset (reset=0, async): state IDLE, divider 0, adc_hold 0, WAIT timer 0. All outputs 0.
- Divider, when enable=1:
  - cnt increments each cycle.
  - tick=1 when cnt >= div_val; cnt then returns to 0. Period is div_val+1; div_val=0 gives a tick every cycle.
  - Comparing with >= makes a live decrease of div_val take effect without a wrap-around.
- Divider, when enable=0: cnt forced to 0, no tick.
- adc_hold loads adc_data on adc_valid. If adc_valid and tick occur in the same cycle, the new adc_data is used (bypass).
- FSM states: IDLE, TRIG, WAIT.
  - IDLE, tick in cycle T: filt_data_in <= sample, next state TRIG.
  - TRIG: filt_sample_trig=1 for exactly cycle T+1, next state WAIT. filt_data_in stays stable until the next trigger.
  - WAIT: timer counts WAIT cycles.
    - filt_done=1 in cycle D: out_data <= filt_data_out, out_valid=1 in cycle D+1, next state IDLE.
    - No done after TIMEOUT WAIT cycles: timeout_flag <= 1, next state IDLE, no out_valid.
- A tick while state != IDLE is dropped and overrun_cnt increments, saturating at all-ones.
- filt_done seen in IDLE or TRIG is ignored and produces no out_valid.
- Ordering: IDLE is re-entered the cycle after done, so a tick in D+1 is accepted.
- clr_status and an overrun increment in the same cycle: clear first, then increment (result 1). clr_status and a timeout in the same cycle: flag ends set.
- enable falling mid-operation: the current TRIG/WAIT sequence completes normally; no further triggers.
- div_val and enable are sampled every cycle; no shadowing.

Decomposition:
- Shared package/include notch_seq_pkg:
  - state encoding localparams (IDLE=2'd0, TRIG=2'd1, WAIT=2'd2)
  - timer width derived as clog2(TIMEOUT+1)
- Sub-module notch_rate_div: divider with enable, div_val in, tick out.
- FSM, sample hold and status logic stay in notch_sequencer.

Test Plan:
1. Reset: drive reset=0 mid-WAIT with random inputs -> all outputs 0 immediately; after release, no trig until the first tick.
2. Basic flow: div_val=9, enable=1, adc_data=24'h123456 steady; filter model asserts done 5 cycles after trig, returns 24'h0F0F0F.
   -> trig every 10 cycles, filt_data_in=24'h123456, out_valid 1 cycle after done with out_data=24'h0F0F0F, overrun_cnt=0.
3. Overrun: div_val=3, filter done latency 10 -> ticks dropped while busy; overrun_cnt increments per dropped tick and saturates at 255 after a long run; clr_status returns it to 0.
4. Timeout: filter never asserts done -> timeout_flag=1 after 64 WAIT cycles, busy falls, no out_valid; the next tick triggers normally; clr_status clears the flag.
5. Boundaries: div_val=0 gives a tick every cycle. adc_valid coinciding with tick -> new sample latched. Spurious done in IDLE -> no out_valid.
6. div_val lowered from 100 to 5 while cnt=50 -> tick on the next cycle, then period 6. enable dropped during WAIT -> current result still delivered, no further trig.
